crossbar_egress_rx: RTL and testbench

CROSSBAR_EGRESS_RX -- requirements
Module: crossbar_egress_rx

---
 rtl/xbar_pkg.sv | 19 +
 rtl/crossbar_egress_rx_if.sv | 25 ++
 rtl/xbar_sync_fifo.sv | 77 +++++++
 rtl/crossbar_egress_rx.sv | 82 ++++++++
 tb/tb_crossbar_egress_rx.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: port count, select width, default payload width
// and the saturating counter helper used by the egress receivers.
package xbar_pkg;

   localparam int XBAR_PORTS = 16;
   localparam int XBAR_SEL_W = 4;
   localparam int XBAR_WIDTH = 320;

   typedef logic [15:0] drop_cnt_t;

   function automatic drop_cnt_t sat_inc16(input drop_cnt_t v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

endpackage

// File: rtl/crossbar_egress_rx_if.sv
// Crossbar output port (valid in the top bit) plus the downstream valid/ready stream.
interface crossbar_egress_rx_if import xbar_pkg::*; #(
   parameter int WIDTH = XBAR_WIDTH
);
   logic [WIDTH:0]   xbar_out;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;

   // environment side: drives the crossbar port and the downstream ready
   modport master (
      output xbar_out,
      output m_ready,
      input  m_valid,
      input  m_data
   );

   // egress receiver side
   modport slave (
      input  xbar_out,
      input  m_ready,
      output m_valid,
      output m_data
   );
endinterface

// File: rtl/xbar_sync_fifo.sv
// Synchronous FIFO: wrapping pointers, separate occupancy count, flush, and a
// drop indication for pushes that find no free slot.
module xbar_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    count_nxt,
   output logic             drop
);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             full_s;
   logic             pop_s;
   logic             push_s;
   logic [CW-1:0]    count_nxt_s;

   // a pop frees the head slot in time for a simultaneous push when full
   always_comb begin
      full_s      = (count_r == FULL_C);
      pop_s       = pop && (count_r != {CW{1'b0}});
      push_s      = push && (!full_s || pop_s);
      drop        = push && full_s && !pop_s && !flush;
      count_nxt_s = count_r;
      if (flush) begin
         count_nxt_s = {CW{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_nxt_s;
      end
   end

   // storage is not reset; contents are only observed through a valid head
   always_ff @(posedge clk) begin
      if (push_s && !flush && !rst) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   assign rd_data   = mem_r[rd_ptr_r];
   assign count     = count_r;
   assign count_nxt = count_nxt_s;

endmodule

// File: rtl/crossbar_egress_rx.sv
// Egress receiver for one crossbar output port: buffers valid beats, streams them
// downstream, and tracks overflow drops, high-water mark and almost-full.
module crossbar_egress_rx import xbar_pkg::*; #(
   parameter  int WIDTH     = XBAR_WIDTH,
   parameter  int DEPTH     = 16,
   parameter  int AF_THRESH = 12,
   localparam int CW        = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   crossbar_egress_rx_if.slave  bus,
   input  logic                 flush,
   output logic [CW-1:0]        count,
   output logic                 almost_full,
   output logic [15:0]          drop_cnt,
   output logic [CW-1:0]        hwm
);
   localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);

   logic            pop_s;
   logic            drop_s;
   logic [CW-1:0]   count_s;
   logic [CW-1:0]   count_nxt_s;
   logic            m_valid_r;
   logic            af_r;
   drop_cnt_t       drop_cnt_r;
   logic [CW-1:0]   hwm_r;

   assign pop_s = m_valid_r && bus.m_ready;

   xbar_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.xbar_out[WIDTH]),
      .pop       (pop_s),
      .flush     (flush),
      .wr_data   (bus.xbar_out[WIDTH-1:0]),
      .rd_data   (bus.m_data),
      .count     (count_s),
      .count_nxt (count_nxt_s),
      .drop      (drop_s)
   );

   // status flags follow the next occupancy so they match the count register
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_r <= 1'b0;
         af_r      <= 1'b0;
      end else begin
         m_valid_r <= (count_nxt_s != {CW{1'b0}});
         af_r      <= (count_nxt_s >= AF_C);
      end
   end

   // drop counter survives flush; only reset clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_r <= 16'h0000;
      end else if (drop_s) begin
         drop_cnt_r <= sat_inc16(drop_cnt_r);
      end
   end

   // high-water mark of occupancy since the last reset or flush
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         hwm_r <= {CW{1'b0}};
      end else if (count_nxt_s > hwm_r) begin
         hwm_r <= count_nxt_s;
      end
   end

   assign bus.m_valid = m_valid_r;
   assign count       = count_s;
   assign almost_full = af_r;
   assign drop_cnt    = drop_cnt_r;
   assign hwm         = hwm_r;

endmodule

// File: tb/tb_crossbar_egress_rx.sv
// Directed and random stimulus for crossbar_egress_rx (WIDTH=8, DEPTH=4),
// checked every cycle against a queue-based reference model.
module tb_crossbar_egress_rx;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int AF = 3;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        flush = 1'b0;
   logic [2:0]  count;
   logic        almost_full;
   logic [15:0] drop_cnt;
   logic [2:0]  hwm;

   int n_assert = 0;
   int n_fail   = 0;

   logic [W-1:0] q[$];
   int m_drop = 0;
   int m_hwm  = 0;

   crossbar_egress_rx_if #(.WIDTH(W)) bus();

   crossbar_egress_rx #(
      .WIDTH     (W),
      .DEPTH     (D),
      .AF_THRESH (AF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .flush       (flush),
      .count       (count),
      .almost_full (almost_full),
      .drop_cnt    (drop_cnt),
      .hwm         (hwm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy);
      bus.xbar_out = {v, d};
      bus.m_ready  = rdy;
   endtask

   // behavioural effect of one clock edge, from the current inputs
   task automatic model_edge();
      if (rst) begin
         q.delete();
         m_drop = 0;
         m_hwm  = 0;
      end else if (flush) begin
         q.delete();
         m_hwm = 0;
      end else begin
         if (q.size() != 0 && bus.m_ready) void'(q.pop_front());
         if (bus.xbar_out[W]) begin
            if (q.size() < D) q.push_back(bus.xbar_out[W-1:0]);
            else if (m_drop < 65535) m_drop++;
         end
         if (q.size() > m_hwm) m_hwm = q.size();
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".m_valid"}, 32'(bus.m_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk({tag, ".m_data"}, 32'(bus.m_data), 32'(q[0]));
      chk({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AF));
      chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
      chk({tag, ".hwm"}, 32'(hwm), 32'(m_hwm));
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [7:0] dv;
      int saved;
      drive(1'b0, 8'h00, 1'b0);

      // reset
      tick("reset0");
      tick("reset1");
      chk("reset.count", 32'(count), 32'd0);
      chk("reset.m_valid", 32'(bus.m_valid), 32'd0);
      rst = 1'b0;

      // three back-to-back pushes with a ready sink
      drive(1'b1, 8'hA1, 1'b1); tick("seq.a1");
      chk("seq.first", 32'(bus.m_data), 32'h0000_00A1);
      drive(1'b1, 8'hA2, 1'b1); tick("seq.a2");
      chk("seq.second", 32'(bus.m_data), 32'h0000_00A2);
      drive(1'b1, 8'hA3, 1'b1); tick("seq.a3");
      chk("seq.third", 32'(bus.m_data), 32'h0000_00A3);
      drive(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) tick("seq.idle");
      chk("seq.no_drop", 32'(drop_cnt), 32'd0);

      // overflow with a stalled sink, then drain
      for (int i = 0; i < 6; i++) begin
         dv = 8'h10 + 8'(i);
         drive(1'b1, dv, 1'b0);
         tick("ovf.push");
      end
      chk("ovf.count", 32'(count), 32'd4);
      chk("ovf.hwm", 32'(hwm), 32'd4);
      chk("ovf.drop", 32'(drop_cnt), 32'd2);
      for (int i = 0; i < 4; i++) begin
         chk("ovf.drain", 32'(bus.m_data), 32'h10 + 32'(i));
         drive(1'b0, 8'h00, 1'b1);
         tick("ovf.drain");
      end

      // push and pop on the same edge while full
      for (int i = 0; i < 4; i++) begin
         dv = 8'h30 + 8'(i);
         drive(1'b1, dv, 1'b0);
         tick("full.fill");
      end
      drive(1'b1, 8'h20, 1'b1); tick("full.pushpop");
      chk("full.count", 32'(count), 32'd4);
      chk("full.drop", 32'(drop_cnt), 32'd2);
      drive(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) tick("full.drain");
      chk("full.last", 32'(bus.m_data), 32'h0000_0020);
      tick("full.empty");

      // ten beats with ready toggling, across pointer wrap
      for (int i = 0; i < 10; i++) begin
         dv = 8'h40 + 8'(i);
         drive(1'b1, dv, 1'(i % 2));
         tick("wrap.push");
      end
      drive(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 6; i++) tick("wrap.drain");

      // flush together with a push at count=3
      for (int i = 0; i < 3; i++) begin
         dv = 8'h50 + 8'(i);
         drive(1'b1, dv, 1'b0);
         tick("flush.fill");
      end
      saved = m_drop;
      flush = 1'b1;
      drive(1'b1, 8'h5F, 1'b1);
      tick("flush.edge");
      flush = 1'b0;
      chk("flush.count", 32'(count), 32'd0);
      chk("flush.m_valid", 32'(bus.m_valid), 32'd0);
      chk("flush.hwm", 32'(hwm), 32'd0);
      chk("flush.drop", 32'(drop_cnt), 32'(saved));
      drive(1'b0, 8'h00, 1'b0);
      tick("flush.idle");

      // random traffic with occasional flush and reset
      for (int i = 0; i < 1500; i++) begin
         dv = 8'($urandom);
         drive(1'($urandom_range(0, 3) != 0), dv, 1'($urandom_range(0, 2) == 0));
         flush = ($urandom_range(0, 63) == 0);
         rst   = ($urandom_range(0, 255) == 0);
         tick("rand");
      end
      flush = 1'b0;
      rst   = 1'b1;
      tick("sat.reset");
      rst = 1'b0;

      // drive the drop counter up to saturation
      drive(1'b1, 8'h77, 1'b0);
      for (int i = 0; i < 4 + 65534; i++) tick("sat.fill");
      chk("sat.fffe", 32'(drop_cnt), 32'h0000_FFFE);
      for (int i = 0; i < 3; i++) tick("sat.over");
      chk("sat.ffff", 32'(drop_cnt), 32'h0000_FFFF);
      rst = 1'b1;
      drive(1'b1, 8'h88, 1'b1);
      tick("sat.rst");
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst.almost_full", 32'(almost_full), 32'd0);
      chk("rst.drop", 32'(drop_cnt), 32'd0);
      chk("rst.hwm", 32'(hwm), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
